// File: rtl/rtc_bcd_read_seq.sv
// Reads NUM_REGS consecutive BCD RTC registers via a shared BCD->binary converter in one start/done transaction.
// Optional build macro RANGE_CHECK_EN adds per-slot limit checks on the converted values.
module rtc_bcd_read_seq #(
    parameter int          NUM_REGS  = 6,
    parameter logic [7:0]  BASE_ADDR = 8'h21
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NUM_REGS-1:0]     err_mask,
    output logic                    rd_req,
    output logic [7:0]              rd_addr,
    input  logic                    rd_ack,
    input  logic [7:0]              rd_data,
    output logic [7:0]              conv_bcd,
    input  logic [6:0]              conv_bin,
    output logic [7*NUM_REGS-1:0]   time_bin,
    output logic [2:0]              dbg_state
);

    // Bus handshake: rd_req rises in REQ and stays high, with rd_addr stable,
    // until the cycle in which rd_ack=1; rd_data is taken in that same cycle.
    localparam int         IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [6:0] BAD_VAL = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LATCH = 3'd2,
        S_CONV  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              conv_bcd_q, conv_bcd_d;
    logic [7*NUM_REGS-1:0]   time_bin_q, time_bin_d;
    logic [NUM_REGS-1:0]     err_mask_q, err_mask_d;
    logic                    err_q, err_d;
    logic                    range_bad;
    logic                    slot_bad;

`ifdef RANGE_CHECK_EN
    function automatic logic [6:0] slot_limit(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1: slot_limit = 7'd59;
            3'd2:       slot_limit = 7'd23;
            3'd3:       slot_limit = 7'd31;
            3'd4:       slot_limit = 7'd12;
            default:    slot_limit = 7'd99;
        endcase
    endfunction

    // Date and month have no zero value.
    assign range_bad = (conv_bin > slot_limit(idx_q)) ||
                       ((conv_bin == 7'd0) && ((idx_q == 3'd3) || (idx_q == 3'd4)));
`else
    assign range_bad = 1'b0;
`endif

    assign slot_bad = (conv_bin == BAD_VAL) || range_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            conv_bcd_q <= '0;
            time_bin_q <= '0;
            err_mask_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            conv_bcd_q <= conv_bcd_d;
            time_bin_q <= time_bin_d;
            err_mask_q <= err_mask_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        conv_bcd_d = conv_bcd_q;
        time_bin_d = time_bin_q;
        err_mask_d = err_mask_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_REQ;
                    idx_d      = '0;
                    err_mask_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    conv_bcd_d = rd_data;
                    state_d    = S_LATCH;
                end
            end
            S_LATCH: state_d = S_CONV;
            S_CONV: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        time_bin_d[7*i +: 7] = slot_bad ? BAD_VAL : conv_bin;
                        err_mask_d[i]        = err_mask_q[i] | slot_bad;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    err_d   = |err_mask_d;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_REQ) || (state_q == S_LATCH) || (state_q == S_CONV);
    assign done      = (state_q == S_DONE);
    assign rd_req    = (state_q == S_REQ);
    assign rd_addr   = (state_q == S_REQ) ? (BASE_ADDR + 8'(idx_q)) : 8'h00;
    assign err       = err_q;
    assign err_mask  = err_mask_q;
    assign conv_bcd  = conv_bcd_q;
    assign time_bin  = time_bin_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bcd_read_seq.sv
// Bench for rtc_bcd_read_seq: RTC responder, behavioural converter, expected-value queue per transaction.
module tb_rtc_bcd_read_seq;

    localparam int NR = 6;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic [NR-1:0]   err_mask;
    logic            rd_req;
    logic [7:0]      rd_addr;
    logic            rd_ack;
    logic [7:0]      rd_data;
    logic [7:0]      conv_bcd;
    logic [6:0]      conv_bin;
    logic [7*NR-1:0] time_bin;
    logic [2:0]      dbg_state;

    int              vectors = 0;
    int              miscompares = 0;
    logic [6:0]      exp_q[$];
    logic [7:0]      mem[8];
    int              ack_wait[8];
    int              resp_slot;
    int              req_cnt;
    logic            spurious;

    rtc_bcd_read_seq #(.NUM_REGS(NR), .BASE_ADDR(8'h21)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .err(err), .err_mask(err_mask), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .conv_bcd(conv_bcd), .conv_bin(conv_bin),
        .time_bin(time_bin), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external BCD->binary converter
    always_comb begin
        conv_bin = 7'h7F;
        if (conv_bcd[7:4] <= 4'd9 && conv_bcd[3:0] <= 4'd9)
            conv_bin = 7'(conv_bcd[7:4] * 10 + conv_bcd[3:0]);
    end

    function automatic logic [6:0] model(input int slot, input logic [7:0] bcd);
        int v;
        int lim;
        if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) return 7'h7F;
        v = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
`ifdef RANGE_CHECK_EN
        lim = (slot <= 1) ? 59 : (slot == 2) ? 23 : (slot == 3) ? 31 : (slot == 4) ? 12 : 99;
        if (v > lim || (v == 0 && (slot == 3 || slot == 4))) return 7'h7F;
`else
        lim = 0;
`endif
        return 7'(v + lim * 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RTC responder: acks after ack_wait[slot] extra cycles of rd_req
    initial begin
        rd_ack = 1'b0; rd_data = 8'h00; resp_slot = 0; req_cnt = 0;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            if (busy !== 1'b1) resp_slot = 0;
            if (spurious) begin
                rd_ack = 1'b1; rd_data = 8'h77;
            end else if (rd_req === 1'b1) begin
                req_cnt++;
                check("rd_addr", 64'(rd_addr), 64'(8'h21 + 8'(resp_slot)));
                if (req_cnt == ack_wait[resp_slot] + 1) begin
                    rd_ack = 1'b1; rd_data = mem[resp_slot & 7];
                    resp_slot++; req_cnt = 0;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    task automatic run_txn(input string tag, input int exp_cycles, input bit poke);
        logic [NR-1:0] exp_mask;
        logic [6:0]    e;
        int            cyc;
        int            extra;
        exp_mask = '0;
        for (int i = 0; i < NR; i++) begin
            e = model(i, mem[i]);
            exp_q.push_back(e);
            if (e == 7'h7F) exp_mask[i] = 1'b1;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, 64'(busy), 64'(1));
        while (cyc < 200) begin
            if (done === 1'b1) break;
            start = poke && (cyc == 5);
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cycles));
        check({tag, "_busy_done"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(|exp_mask));
        check({tag, "_err_mask"}, 64'(err_mask), 64'(exp_mask));
        for (int i = 0; i < NR; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_slot%0d", tag, i), 64'(time_bin[7*i +: 7]), 64'(e));
        end
        if (poke) begin
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            extra = 0;
            for (int k = 0; k < 10; k++) begin
                if (done === 1'b1 || busy === 1'b1) extra++;
                @(negedge clk);
            end
            check({tag, "_no_restart"}, 64'(extra), 64'(0));
        end
    endtask

    task automatic set_nominal();
        mem[0] = 8'h59; mem[1] = 8'h45; mem[2] = 8'h23;
        mem[3] = 8'h31; mem[4] = 8'h12; mem[5] = 8'h16;
        mem[6] = 8'h00; mem[7] = 8'h00;
        for (int i = 0; i < 8; i++) ack_wait[i] = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; start = 1'b0; spurious = 1'b0;
        set_nominal();
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_req", 64'(rd_req), 64'(0));
        check("rst_time_bin", 64'(time_bin), 64'(0));
        check("rst_err_mask", 64'(err_mask), 64'(0));
        check("rst_conv_bcd", 64'(conv_bcd), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("nominal", 25, 1'b0);

        mem[2] = 8'h3A;
        run_txn("invalid", 25, 1'b0);
        repeat (3) @(negedge clk);
        check("err_hold", 64'(err), 64'(1));
        check("err_mask_hold", 64'(err_mask), 64'(6'b000100));

        set_nominal();
        ack_wait[0] = 5;
        run_txn("slow", 29, 1'b0);

        set_nominal();
        run_txn("ignore", 25, 1'b1);
        run_txn("after_ignore", 25, 1'b0);

        mem[2] = 8'h25;
        run_txn("range", 25, 1'b0);

        // stray ack while idle must not touch the converter register
        spurious = 1'b1;
        @(negedge clk); @(negedge clk);
        spurious = 1'b0;
        @(negedge clk);
        check("stray_ack_conv", 64'(conv_bcd), 64'(8'h16));
        check("stray_ack_busy", 64'(busy), 64'(0));

        set_nominal();
        ack_wait[0] = 10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("mid_req_rd_req", 64'(rd_req), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("arst_rd_req", 64'(rd_req), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_time_bin", 64'(time_bin), 64'(0));
        check("arst_err_mask", 64'(err_mask), 64'(0));
        check("arst_rd_addr", 64'(rd_addr), 64'(0));
        @(negedge clk); reset_n = 1'b1;
        set_nominal();
        repeat (2) @(negedge clk);
        run_txn("recover", 25, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
